operand_fetch: RTL and testbench

- Pipeline stage directly downstream of the core register file.
- Accepts decoded instructions from decode over a valid/ready handshake and drives the register file read addresses.
- Captures instruction metadata and presents resolved source operands to execute.
- Corrects the register file's write/read same-edge hazard with a writeback bypass, and holds operands coherent across stalls.

---
 rtl/operand_fetch.sv | 145 ++++++++++++++
 tb/tb_operand_fetch.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch.sv
// -----------------------------------------------------------------------------
// operand_fetch
//
// Pipeline stage between decode and execute. Accepts a decoded instruction,
// drives the register file read addresses, captures the instruction metadata
// and presents resolved source operands to execute. A writeback bypass covers
// the register file's same-edge write/read hazard (the register file samples
// the old value on the edge it is written). While stalled, the held source
// registers are re-read on every advance edge, so operands stay coherent with
// any later writeback.
//
// Handshake (both sides): a transfer happens on a posedge clk with clk_en=1
// where valid && ready. valid holds, and its payload stays stable, until that
// transfer. ready never depends on valid of the same side.
//
// Ports:
//   clk, rst_n         core clock, asynchronous active-low reset
//   clk_en             global stall; nothing changes while low
//   flush              discard the held instruction (wins over an accept)
//   in_valid/in_ready  decode handshake; in_rs1/in_rs2/in_rd/in_pc payload
//   ra1/ra2            register file read addresses
//   rd1/rd2            register file read data (registered inside the file)
//   wb_we/wb_wa/wb_wd  writeback port, same signals the register file sees
//   out_valid/out_ready  execute handshake
//   out_op1/out_op2    resolved operands
//   out_rs1/out_rs2/out_rd/out_pc  held instruction metadata
//   dbg_byp1_v/dbg_byp2_v  bypass flags, exposed for checkers
// -----------------------------------------------------------------------------
module operand_fetch #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int PC_W       = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clk_en,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [REG_ADDR_W-1:0] in_rs1,
    input  logic [REG_ADDR_W-1:0] in_rs2,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic [PC_W-1:0]       in_pc,
    output logic [REG_ADDR_W-1:0] ra1,
    output logic [REG_ADDR_W-1:0] ra2,
    input  logic [XLEN-1:0]       rd1,
    input  logic [XLEN-1:0]       rd2,
    input  logic                  wb_we,
    input  logic [REG_ADDR_W-1:0] wb_wa,
    input  logic [XLEN-1:0]       wb_wd,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       out_op1,
    output logic [XLEN-1:0]       out_op2,
    output logic [REG_ADDR_W-1:0] out_rs1,
    output logic [REG_ADDR_W-1:0] out_rs2,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic [PC_W-1:0]       out_pc,
    output logic                  dbg_byp1_v,
    output logic                  dbg_byp2_v
);

    logic                  out_valid_q, out_valid_d;
    logic [REG_ADDR_W-1:0] rs1_q, rs1_d;
    logic [REG_ADDR_W-1:0] rs2_q, rs2_d;
    logic [REG_ADDR_W-1:0] rd_q, rd_d;
    logic [PC_W-1:0]       pc_q, pc_d;
    logic                  byp1_v_q, byp1_v_d;
    logic                  byp2_v_q, byp2_v_d;
    logic [XLEN-1:0]       byp1_d_q, byp1_d_d;
    logic [XLEN-1:0]       byp2_d_q, byp2_d_d;
    logic                  accept;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // When stalled the file re-reads the held sources, so a write landing
    // during the stall is picked up by the next re-read (or the bypass).
    assign ra1 = in_ready ? in_rs1 : rs1_q;
    assign ra2 = in_ready ? in_rs2 : rs2_q;

    always_comb begin
        out_valid_d = out_valid_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        rd_d        = rd_q;
        pc_d        = pc_q;

        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            rs1_d       = in_rs1;
            rs2_d       = in_rs2;
            rd_d        = in_rd;
            pc_d        = in_pc;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        // The register file returns the pre-write value when it reads and
        // writes the same index on one edge; remember the written data.
        byp1_v_d = !flush && wb_we && (wb_wa == ra1) && (ra1 != '0);
        byp2_v_d = !flush && wb_we && (wb_wa == ra2) && (ra2 != '0);
        byp1_d_d = wb_wd;
        byp2_d_d = wb_wd;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            pc_q        <= '0;
            byp1_v_q    <= 1'b0;
            byp2_v_q    <= 1'b0;
            byp1_d_q    <= '0;
            byp2_d_q    <= '0;
        end else if (clk_en) begin
            out_valid_q <= out_valid_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            rd_q        <= rd_d;
            pc_q        <= pc_d;
            byp1_v_q    <= byp1_v_d;
            byp2_v_q    <= byp2_v_d;
            byp1_d_q    <= byp1_d_d;
            byp2_d_q    <= byp2_d_d;
        end
    end

    // x0 reads as zero no matter what the file or bypass hold.
    assign out_op1 = (rs1_q == '0) ? '0 : (byp1_v_q ? byp1_d_q : rd1);
    assign out_op2 = (rs2_q == '0) ? '0 : (byp2_v_q ? byp2_d_q : rd2);

    assign out_valid  = out_valid_q;
    assign out_rs1    = rs1_q;
    assign out_rs2    = rs2_q;
    assign out_rd     = rd_q;
    assign out_pc     = pc_q;
    assign dbg_byp1_v = byp1_v_q;
    assign dbg_byp2_v = byp2_v_q;

endmodule

// File: tb/tb_operand_fetch.sv
module tb_operand_fetch;

    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int PW   = 32;
    localparam int W    = 3 * AW + PW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clk_en;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_rs1, in_rs2, in_rd;
    logic [PW-1:0] in_pc;
    logic [AW-1:0] ra1, ra2;
    logic [XLEN-1:0] rd1, rd2;
    logic          wb_we;
    logic [AW-1:0] wb_wa;
    logic [XLEN-1:0] wb_wd;
    logic          out_valid;
    logic          out_ready;
    logic [XLEN-1:0] out_op1, out_op2;
    logic [AW-1:0] out_rs1, out_rs2, out_rd;
    logic [PW-1:0] out_pc;
    logic          dbg_byp1_v, dbg_byp2_v;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    operand_fetch #(.XLEN(XLEN), .REG_ADDR_W(AW), .PC_W(PW)) dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_pc(in_pc),
        .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op1(out_op1), .out_op2(out_op2),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_pc(out_pc),
        .dbg_byp1_v(dbg_byp1_v), .dbg_byp2_v(dbg_byp2_v)
    );

    // Register file model: registered read, same-edge write returns old data.
    logic [XLEN-1:0] regs [32];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd1 <= '0;
            rd2 <= '0;
        end else if (clk_en) begin
            rd1 <= regs[ra1];
            rd2 <= regs[ra2];
            if (wb_we) regs[wb_wa] <= wb_wd;
        end
    end

    function automatic logic [XLEN-1:0] arch(input logic [AW-1:0] r);
        return (r == '0) ? '0 : regs[r];
    endfunction

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];

    always @(negedge clk) begin
        logic [W-1:0] e;
        if (rst_n && clk_en) begin
            if (out_valid && flush) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end else if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_output", 64'(out_pc), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_rs1", 64'(out_rs1), 64'(e[W-1 -: AW]));
                    check("sb_rs2", 64'(out_rs2), 64'(e[W-AW-1 -: AW]));
                    check("sb_rd",  64'(out_rd),  64'(e[W-2*AW-1 -: AW]));
                    check("sb_pc",  64'(out_pc),  64'(e[PW-1:0]));
                    check("sb_op1", 64'(out_op1), 64'(arch(e[W-1 -: AW])));
                    check("sb_op2", 64'(out_op2), 64'(arch(e[W-AW-1 -: AW])));
                end
            end
            if (in_valid && in_ready && !flush)
                exp_q.push_back({in_rs1, in_rs2, in_rd, in_pc});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_in(input logic v, input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                            input logic [AW-1:0] d, input logic [PW-1:0] pc);
        in_valid = v;
        in_rs1   = r1;
        in_rs2   = r2;
        in_rd    = d;
        in_pc    = pc;
    endtask

    task automatic drive_wb(input logic we, input logic [AW-1:0] wa, input logic [XLEN-1:0] wd);
        wb_we = we;
        wb_wa = wa;
        wb_wd = wd;
    endtask

    // ---------------- stimulus ----------------
    logic [XLEN-1:0] saved_op1;

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = $urandom();
        regs[5] = 32'h1234;
        regs[7] = 32'h1;

        rst_n = 1'b0; clk_en = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive_in(1'b0, '0, '0, '0, '0);
        drive_wb(1'b0, '0, '0);
        tick(); tick();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_rs1",   64'(out_rs1),   64'd0);
        check("rst_out_pc",    64'(out_pc),    64'd0);
        check("rst_out_op1",   64'(out_op1),   64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        rst_n = 1'b1;
        tick();

        // Basic read
        drive_in(1'b1, 5'd5, 5'd0, 5'd3, 32'h100);
        tick();
        drive_in(1'b0, '0, '0, '0, '0);
        check("basic_valid", 64'(out_valid), 64'd1);
        check("basic_op1",   64'(out_op1),   64'h1234);
        check("basic_op2",   64'(out_op2),   64'd0);
        out_ready = 1'b1;
        tick();
        check("basic_drained", 64'(out_valid), 64'd0);

        // Same-edge bypass, then stall coherence
        drive_in(1'b1, 5'd7, 5'd5, 5'd4, 32'h200);
        drive_wb(1'b1, 5'd7, 32'hDEAD);
        tick();
        drive_in(1'b0, '0, '0, '0, '0);
        drive_wb(1'b0, '0, '0);
        out_ready = 1'b0;
        check("byp_op1", 64'(out_op1), 64'hDEAD);
        check("byp_op2", 64'(out_op2), 64'h1234);
        tick();
        check("stall1_op1",      64'(out_op1),  64'hDEAD);
        check("stall1_in_ready", 64'(in_ready), 64'd0);
        drive_wb(1'b1, 5'd7, 32'hBEEF);
        tick();
        drive_wb(1'b0, '0, '0);
        check("stall2_op1",      64'(out_op1),   64'hBEEF);
        check("stall2_valid",    64'(out_valid), 64'd1);
        check("stall2_in_ready", 64'(in_ready),  64'd0);
        tick();
        check("stall3_op1",   64'(out_op1),   64'hBEEF);
        check("stall3_valid", 64'(out_valid), 64'd1);
        check("stall3_pc",    64'(out_pc),    64'h200);
        out_ready = 1'b1;
        tick();

        // x0 write at accept
        drive_in(1'b1, 5'd0, 5'd7, 5'd1, 32'h300);
        drive_wb(1'b1, 5'd0, 32'hFFFF);
        tick();
        drive_in(1'b0, '0, '0, '0, '0);
        drive_wb(1'b0, '0, '0);
        check("x0_op1",   64'(out_op1),    64'd0);
        check("x0_op2",   64'(out_op2),    64'hBEEF);
        check("x0_nobyp", 64'(dbg_byp1_v), 64'd0);
        tick();

        // Random back-to-back traffic with writebacks
        for (int i = 0; i < 60; i++) begin
            drive_in(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                     5'($urandom_range(0, 31)), 32'h1000 + 32'(i));
            drive_wb(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom());
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        drive_in(1'b0, '0, '0, '0, '0);
        drive_wb(1'b0, '0, '0);

        // Flush wins over a simultaneous accept
        out_ready = 1'b0;
        flush = 1'b1;
        drive_in(1'b1, 5'd5, 5'd5, 5'd2, 32'h400);
        tick();
        flush = 1'b0;
        drive_in(1'b0, '0, '0, '0, '0);
        check("flush_valid", 64'(out_valid), 64'd0);
        tick();
        check("flush_stays_empty", 64'(out_valid), 64'd0);

        // clk_en low freezes everything
        drive_in(1'b1, 5'd5, 5'd7, 5'd9, 32'h600);
        tick();
        saved_op1 = arch(5'd5);
        drive_in(1'b1, 5'd1, 5'd2, 5'd3, 32'h700);
        drive_wb(1'b1, 5'd5, 32'h5555);
        out_ready = 1'b1;
        clk_en = 1'b0;
        tick(); tick();
        check("clken_valid", 64'(out_valid), 64'd1);
        check("clken_pc",    64'(out_pc),    64'h600);
        check("clken_op1",   64'(out_op1),   64'(saved_op1));
        drive_in(1'b0, '0, '0, '0, '0);
        drive_wb(1'b0, '0, '0);
        clk_en = 1'b1;
        tick();
        check("clken_drained", 64'(out_valid), 64'd0);

        // Asynchronous reset while stalled
        out_ready = 1'b0;
        drive_in(1'b1, 5'd5, 5'd0, 5'd6, 32'h800);
        tick();
        drive_in(1'b0, '0, '0, '0, '0);
        check("pre_rst_valid", 64'(out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("async_rst_valid", 64'(out_valid), 64'd0);
        check("async_rst_pc",    64'(out_pc),    64'd0);
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick(); tick();
        check("sb_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
